seven_seg_scanner: RTL and testbench



---
 rtl/seven_seg_scanner.sv | 110 +++++++++++
 tb/tb_seven_seg_scanner.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: 3-digit hex 7-segment scan controller with blanking gaps,
// per-frame value snapshot and optional leading-zero suppression.
module seven_seg_scanner #(
    parameter int unsigned CLK_DIV      = 100000,
    parameter int unsigned BLANK_CYCLES = 1000,
    parameter bit          LZ_SUPPRESS  = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [11:0] value,
    output logic [1:0]  sel,
    output logic [6:0]  seg,
    output logic        frame_start
);
    localparam int unsigned CMAX = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
    localparam int CW = $clog2(CMAX);

    typedef enum logic [1:0] {GAP, SHOW, OFF} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [1:0]    digit, digit_n;
    logic [11:0]   shadow, shadow_n;
    logic [3:0]    nib;
    logic          blank;
    logic [1:0]    sel_n;
    logic [6:0]    seg_n;
    logic          fs_n;

    function automatic logic [6:0] hex7(input logic [3:0] h);
        case (h)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    // In GAP, digit holds the next digit to show; in SHOW, the current one.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt + 1'b1;
        digit_n  = digit;
        shadow_n = shadow;
        fs_n     = 1'b0;
        if (!enable) begin
            state_n = OFF;
            cnt_n   = '0;
        end else begin
            case (state)
                OFF: begin
                    state_n = GAP;
                    cnt_n   = '0;
                    digit_n = 2'd0;
                end
                GAP: if (cnt == CW'(BLANK_CYCLES - 1)) begin
                    state_n = SHOW;
                    cnt_n   = '0;
                    if (digit == 2'd0) begin
                        shadow_n = value;
                        fs_n     = 1'b1;
                    end
                end
                default: if (cnt == CW'(CLK_DIV - 1)) begin
                    state_n = GAP;
                    cnt_n   = '0;
                    digit_n = (digit == 2'd2) ? 2'd0 : digit + 2'd1;
                end
            endcase
        end
        nib   = (digit_n == 2'd2) ? shadow_n[11:8] : (digit_n == 2'd1) ? shadow_n[7:4] : shadow_n[3:0];
        blank = LZ_SUPPRESS && ((digit_n == 2'd2 && shadow_n[11:8] == 4'h0) ||
                                (digit_n == 2'd1 && shadow_n[11:4] == 8'h00));
        sel_n = (state_n == SHOW) ? digit_n : 2'd3;
        seg_n = (state_n == SHOW && !blank) ? hex7(nib) : 7'h7F;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= GAP;
            cnt         <= '0;
            digit       <= 2'd0;
            shadow      <= '0;
            sel         <= 2'd3;
            seg         <= 7'h7F;
            frame_start <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            digit       <= digit_n;
            shadow      <= shadow_n;
            sel         <= sel_n;
            seg         <= seg_n;
            frame_start <= fs_n;
        end
    end
endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner: directed checks of frame timing, leading-zero blanking,
// snapshotting, enable and async reset, plus a randomized gap/spacing checker.
module tb_seven_seg_scanner;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic [11:0] value = '0;
    logic [1:0]  sel0, sel1;
    logic [6:0]  seg0, seg1;
    logic        fs0, fs1;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [1:0] exp_sel [18];

    always #5 clk = ~clk;

    seven_seg_scanner #(.CLK_DIV(4), .BLANK_CYCLES(2), .LZ_SUPPRESS(1'b0)) u0 (
        .clk(clk), .reset(reset), .enable(enable), .value(value),
        .sel(sel0), .seg(seg0), .frame_start(fs0));

    seven_seg_scanner #(.CLK_DIV(4), .BLANK_CYCLES(2), .LZ_SUPPRESS(1'b1)) u1 (
        .clk(clk), .reset(reset), .enable(enable), .value(value),
        .sel(sel1), .seg(seg1), .frame_start(fs1));

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic restart(input logic [11:0] v);
        reset  = 1'b1;
        enable = 1'b1;
        value  = v;
        @(negedge clk);
        reset = 1'b0;
        cyc   = 0;
    endtask

    // Checks n cycles against the nominal 18-cycle frame timeline.
    task automatic run(input string tag, input bit lz, input int n,
                       input logic [6:0] e0, input logic [6:0] e1, input logic [6:0] e2);
        logic [1:0] es;
        logic [6:0] eseg;
        for (int k = 0; k < n; k++) begin
            es   = exp_sel[cyc % 18];
            eseg = (es == 2'd3) ? 7'h7F : (es == 2'd0) ? e0 : (es == 2'd1) ? e1 : e2;
            chk({tag, "_sel"}, 8'(lz ? sel1 : sel0), 8'(es));
            chk({tag, "_seg"}, 8'(lz ? seg1 : seg0), 8'(eseg));
            chk({tag, "_fs"}, 8'(lz ? fs1 : fs0), 8'(cyc % 18 == 2));
            @(negedge clk);
            cyc++;
        end
    endtask

    initial begin
        int last_d, gap, last_fs;
        bit dropped;
        exp_sel = '{2'd3, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 2'd3, 2'd1,
                    2'd1, 2'd1, 2'd1, 2'd3, 2'd3, 2'd2, 2'd2, 2'd2, 2'd2};
        @(negedge clk);
        chk("rst_sel", 8'(sel0), 8'd3);
        chk("rst_seg", 8'(seg0), 8'h7F);
        chk("rst_fs", 8'(fs0), 8'd0);

        // Frame sequencing, both instances agree on a value with no leading zeros
        restart(12'h3A7);
        run("seq", 1'b0, 21, 7'b1111000, 7'b0001000, 7'b0110000);
        restart(12'h3A7);
        run("seq_lz", 1'b1, 18, 7'b1111000, 7'b0001000, 7'b0110000);

        // Leading-zero suppression
        restart(12'h005);
        run("lz005", 1'b1, 18, 7'b0010010, 7'h7F, 7'h7F);
        restart(12'h000);
        run("lz000", 1'b1, 18, 7'b1000000, 7'h7F, 7'h7F);
        restart(12'h105);
        run("lz105", 1'b1, 18, 7'b0010010, 7'b1000000, 7'b1111001);
        restart(12'h000);
        run("nolz000", 1'b0, 18, 7'b1000000, 7'b1000000, 7'b1000000);

        // Mid-frame value change is held off until the next snapshot
        restart(12'h111);
        run("snap_a", 1'b1, 8, 7'b1111001, 7'b1111001, 7'b1111001);
        value = 12'h222;
        run("snap_b", 1'b1, 10, 7'b1111001, 7'b1111001, 7'b1111001);
        run("snap_c", 1'b1, 18, 7'b0100100, 7'b0100100, 7'b0100100);

        // Enable drop during SHOW(2)
        restart(12'h3A7);
        run("en_pre", 1'b0, 16, 7'b1111000, 7'b0001000, 7'b0110000);
        chk("en_show2", 8'(sel0), 8'd2);
        enable = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("off_sel", 8'(sel0), 8'd3);
            chk("off_seg", 8'(seg0), 8'h7F);
            chk("off_fs", 8'(fs0), 8'd0);
        end
        enable = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("regap_sel", 8'(sel0), 8'd3);
            chk("regap_fs", 8'(fs0), 8'd0);
        end
        @(negedge clk);
        cyc = 2;
        run("en_resume", 1'b0, 18, 7'b1111000, 7'b0001000, 7'b0110000);

        // Async reset between edges mid-SHOW(1)
        restart(12'h3A7);
        run("ar_pre", 1'b0, 9, 7'b1111000, 7'b0001000, 7'b0110000);
        chk("ar_show1", 8'(sel0), 8'd1);
        #2 reset = 1'b1;
        #1;
        chk("ar_sel", 8'(sel0), 8'd3);
        chk("ar_seg", 8'(seg0), 8'h7F);
        chk("ar_fs", 8'(fs0), 8'd0);
        @(negedge clk);
        reset = 1'b0;
        cyc   = 0;
        run("ar_post", 1'b0, 21, 7'b1111000, 7'b0001000, 7'b0110000);

        // Randomized value/enable: gap invariant and frame spacing
        restart(12'h000);
        last_d  = -1;
        gap     = 0;
        last_fs = -1;
        dropped = 1'b0;
        for (int k = 0; k < 400; k++) begin
            cyc = k;
            if (sel1 == 2'd3) begin
                gap++;
                chk("gap_seg", 8'(seg1), 8'h7F);
            end else begin
                if (last_d >= 0 && int'(sel1) != last_d)
                    chk("gap_len", 8'(gap >= 2), 8'd1);
                last_d = int'(sel1);
                gap    = 0;
            end
            if (fs1) begin
                if (last_fs >= 0 && !dropped)
                    chk("fs_space", 8'(k - last_fs), 8'd18);
                last_fs = k;
                dropped = 1'b0;
            end
            enable = ($urandom_range(0, 59) != 0);
            value  = 12'($urandom);
            if (!enable) dropped = 1'b1;
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
